// File: rtl/hazard3_ahbl_arbiter_pkg.sv
// Shared definitions for the N-port AHB-Lite arbiter.
//   - HTRANS encodings that the arbiter generates or decodes
//   - AHB-Lite sideband field widths
//   - one-hot to index helper, used to drive hmaster
package hazard3_ahbl_arbiter_pkg;

  localparam int W_HTRANS  = 2;
  localparam int W_HSIZE   = 3;
  localparam int W_HPROT   = 4;
  localparam int W_HMASTER = 8;
  localparam int MAX_PORTS = 4;

  localparam logic [W_HTRANS-1:0] HTRANS_IDLE = 2'b00;
  localparam logic [W_HTRANS-1:0] HTRANS_NSEQ = 2'b10;

  // Returns the index of the set bit. Zero when no bit is set.
  function automatic logic [W_HMASTER-1:0] oh_to_idx(input logic [MAX_PORTS-1:0] oh);
    oh_to_idx = '0;
    for (int i = 0; i < MAX_PORTS; i++)
      if (oh[i]) oh_to_idx = W_HMASTER'(i);
  endfunction

endpackage

// File: rtl/hazard3_ahbl_arbiter_if.sv
// Bus bundle for hazard3_ahbl_arbiter.
//   src_* : N_PORTS upstream AHB-Lite masters (packed, port i in element [i])
//   dst_* : the single downstream AHB-Lite master port
// Modports:
//   master : the arbiter's view (it is the master of the downstream bus)
//   slave  : the surrounding system's view (upstream masters + downstream slave)
interface hazard3_ahbl_arbiter_if
  import hazard3_ahbl_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);
  logic [N_PORTS-1:0][W_ADDR-1:0]   src_haddr;
  logic [N_PORTS-1:0]               src_hwrite;
  logic [N_PORTS-1:0][W_HTRANS-1:0] src_htrans;
  logic [N_PORTS-1:0][W_HSIZE-1:0]  src_hsize;
  logic [N_PORTS-1:0][W_HPROT-1:0]  src_hprot;
  logic [N_PORTS-1:0][W_DATA-1:0]   src_hwdata;
  logic [N_PORTS-1:0]               src_hready;
  logic [N_PORTS-1:0]               src_hresp;
  logic [N_PORTS-1:0][W_DATA-1:0]   src_hrdata;

  logic [W_ADDR-1:0]    dst_haddr;
  logic                 dst_hwrite;
  logic [W_HTRANS-1:0]  dst_htrans;
  logic [W_HSIZE-1:0]   dst_hsize;
  logic [W_HPROT-1:0]   dst_hprot;
  logic [W_HMASTER-1:0] dst_hmaster;
  logic [W_DATA-1:0]    dst_hwdata;
  logic                 dst_hready;
  logic                 dst_hresp;
  logic [W_DATA-1:0]    dst_hrdata;

  modport master (
    input  src_haddr, src_hwrite, src_htrans, src_hsize, src_hprot, src_hwdata,
    output src_hready, src_hresp, src_hrdata,
    output dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hprot, dst_hmaster, dst_hwdata,
    input  dst_hready, dst_hresp, dst_hrdata
  );

  modport slave (
    output src_haddr, src_hwrite, src_htrans, src_hsize, src_hprot, src_hwdata,
    input  src_hready, src_hresp, src_hrdata,
    input  dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hprot, dst_hmaster, dst_hwdata,
    output dst_hready, dst_hresp, dst_hrdata
  );

endinterface

// File: rtl/hazard3_ahbl_arbiter_req_buf.sv
// One-entry address-phase capture buffer for one upstream port.
//   load_i    : capture haddr/hwrite/hsize/hprot and mark valid
//   release_i : buffered request was accepted downstream, drop it
//   valid_o and *_o : buffered request
module hazard3_ahbl_arbiter_req_buf
  import hazard3_ahbl_arbiter_pkg::*;
#(
  parameter int W_ADDR = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               release_i,
  input  logic [W_ADDR-1:0]  haddr_i,
  input  logic               hwrite_i,
  input  logic [W_HSIZE-1:0] hsize_i,
  input  logic [W_HPROT-1:0] hprot_i,
  output logic               valid_o,
  output logic [W_ADDR-1:0]  haddr_o,
  output logic               hwrite_o,
  output logic [W_HSIZE-1:0] hsize_o,
  output logic [W_HPROT-1:0] hprot_o
);

  logic valid_q, valid_d;

  // A port that holds a buffered request is stalled, so load and release
  // never coincide in practice; load wins if they ever do.
  always_comb begin
    valid_d = valid_q;
    if (load_i)         valid_d = 1'b1;
    else if (release_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      haddr_o  <= '0;
      hwrite_o <= 1'b0;
      hsize_o  <= '0;
      hprot_o  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        haddr_o  <= haddr_i;
        hwrite_o <= hwrite_i;
        hsize_o  <= hsize_i;
        hprot_o  <= hprot_i;
      end
    end
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/hazard3_ahbl_arbiter.sv
// Fixed-priority (lowest index wins) N-port AHB-Lite arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hazard3_ahbl_arbiter_if.master, upstream src_* and downstream dst_*
// A request that loses arbitration, or is presented during a downstream
// stall, is captured in the port's one-entry buffer and the port is stalled
// until that request's data phase completes.
module hazard3_ahbl_arbiter
  import hazard3_ahbl_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard3_ahbl_arbiter_if.master bus
);

  logic [N_PORTS-1:0] live, req, gnt, buf_valid;
  logic [N_PORTS-1:0] dph_active_q, dph_active_d;
  logic [N_PORTS-1:0] held_gnt_q;
  logic               hold_q, hold_d;

  logic [N_PORTS-1:0][W_ADDR-1:0]  buf_haddr;
  logic [N_PORTS-1:0]              buf_hwrite;
  logic [N_PORTS-1:0][W_HSIZE-1:0] buf_hsize;
  logic [N_PORTS-1:0][W_HPROT-1:0] buf_hprot;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    // Address phase as seen by the master: NSEQ/SEQ while its hready is high.
    assign live[i] = bus.src_htrans[i][1] & bus.src_hready[i];
    assign req[i]  = buf_valid[i] | live[i];

    assign bus.src_hready[i] = dph_active_q[i] ? bus.dst_hready : ~buf_valid[i];
    assign bus.src_hresp[i]  = dph_active_q[i] & bus.dst_hresp;
    assign bus.src_hrdata[i] = bus.dst_hrdata;

    hazard3_ahbl_arbiter_req_buf #(.W_ADDR(W_ADDR)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      // Capture unless this live request goes straight through downstream.
      .load_i   (live[i] & ~(gnt[i] & bus.dst_hready & ~buf_valid[i])),
      .release_i(gnt[i] & bus.dst_hready),
      .haddr_i  (bus.src_haddr[i]),
      .hwrite_i (bus.src_hwrite[i]),
      .hsize_i  (bus.src_hsize[i]),
      .hprot_i  (bus.src_hprot[i]),
      .valid_o  (buf_valid[i]),
      .haddr_o  (buf_haddr[i]),
      .hwrite_o (buf_hwrite[i]),
      .hsize_o  (buf_hsize[i]),
      .hprot_o  (buf_hprot[i])
    );
  end

  // Grant: during a downstream wait state the previous grant is held so the
  // address phase stays stable; otherwise the lowest requesting index wins.
  always_comb begin
    gnt = '0;
    if (hold_q) begin
      gnt = held_gnt_q;
    end else begin
      for (int i = N_PORTS - 1; i >= 0; i--)
        if (req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
    end
  end

  always_comb begin
    bus.dst_haddr  = '0;
    bus.dst_hwrite = 1'b0;
    bus.dst_hsize  = '0;
    bus.dst_hprot  = '0;
    bus.dst_hwdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) begin
        bus.dst_haddr  = buf_valid[i] ? buf_haddr[i]  : bus.src_haddr[i];
        bus.dst_hwrite = buf_valid[i] ? buf_hwrite[i] : bus.src_hwrite[i];
        bus.dst_hsize  = buf_valid[i] ? buf_hsize[i]  : bus.src_hsize[i];
        bus.dst_hprot  = buf_valid[i] ? buf_hprot[i]  : bus.src_hprot[i];
      end
      if (dph_active_q[i]) bus.dst_hwdata = bus.src_hwdata[i];
    end
  end

  assign bus.dst_htrans  = |gnt ? HTRANS_NSEQ : HTRANS_IDLE;
  assign bus.dst_hmaster = oh_to_idx(MAX_PORTS'(gnt));

  // Hold only across plain wait states; an error cycle lets arbitration
  // re-evaluate so the erroring master may withdraw.
  assign hold_d       = bus.dst_htrans[1] & ~bus.dst_hready & ~bus.dst_hresp;
  assign dph_active_d = bus.dst_hready ? gnt : dph_active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= 1'b0;
      held_gnt_q   <= '0;
      dph_active_q <= '0;
    end else begin
      hold_q       <= hold_d;
      held_gnt_q   <= gnt;
      dph_active_q <= dph_active_d;
    end
  end

endmodule
